// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and instruction-memory request sequencer.
// Merges memory wait-states and hazard stalls; handles redirects mid-access.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pipe_stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        x_jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        im_ready_i,
  output logic [31:0] pc_o,
  output logic        im_req_o,
  output logic        fetch_stall_o,
  output logic        misalign_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;

  logic        w_redir;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;
  logic        w_req;
  logic        w_wait;
  logic        w_timeout;

  assign w_redir   = branch_taken_i | x_jump_i;
  assign w_tgt_raw = branch_taken_i ? branch_target_i : jump_target_i;
  assign w_tgt     = {w_tgt_raw[31:2], 2'b00};
  assign w_req     = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_wait    = w_req & ~im_ready_i;
  assign w_timeout = w_wait & (r_cnt == WAIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_err_nxt   = r_err;
    w_cnt_nxt   = w_wait ? r_cnt + 8'd1 : 8'd0;
    misalign_o  = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        misalign_o = w_redir & (w_tgt_raw[1:0] != 2'b00);
        if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_HALT;
        end else if (w_redir && im_ready_i) begin
          w_pc_nxt = w_tgt;
        end else if (w_redir) begin
          w_pend_nxt  = w_tgt;
          w_state_nxt = S_DRAIN;
        end else if (im_ready_i && !pipe_stall_i) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      S_DRAIN: begin
        misalign_o = w_redir & (w_tgt_raw[1:0] != 2'b00);
        // A redirect seen during the drain supersedes the pending one
        if (w_redir) w_pend_nxt = w_tgt;
        if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_HALT;
        end else if (im_ready_i) begin
          w_pc_nxt    = w_redir ? w_tgt : r_pend;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_pend  <= 32'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign pc_o          = r_pc;
  assign im_req_o      = w_req;
  assign err_o         = r_err;
  assign fetch_stall_o = pipe_stall_i
                       | ((r_state == S_FETCH) & ~im_ready_i)
                       | (r_state == S_DRAIN)
                       | (r_state == S_IDLE)
                       | (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pipe_stall;
  logic        br_taken;
  logic [31:0] br_tgt;
  logic        x_jump;
  logic [31:0] j_tgt;
  logic        im_ready;
  logic [31:0] pc;
  logic        im_req;
  logic        f_stall;
  logic        misalign;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(15)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pipe_stall_i   (pipe_stall),
    .branch_taken_i (br_taken),
    .branch_target_i(br_tgt),
    .x_jump_i       (x_jump),
    .jump_target_i  (j_tgt),
    .im_ready_i     (im_ready),
    .pc_o           (pc),
    .im_req_o       (im_req),
    .fetch_stall_o  (f_stall),
    .misalign_o     (misalign),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pipe_stall = 1'b0;
    br_taken   = 1'b0;
    br_tgt     = 32'h0;
    x_jump     = 1'b0;
    j_tgt      = 32'h0;
    im_ready   = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, im_req}, 32'd0);
    chk("rst_stall", {31'd0, f_stall}, 32'd1);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // release; this cycle is IDLE
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, im_req}, 32'd0);
    chk("idle_stall", {31'd0, f_stall}, 32'd1);
    tick();
    chk("first_req", {31'd0, im_req}, 32'd1);
    chk("first_stall", {31'd0, f_stall}, 32'd0);
    chk("pc0", pc, 32'h0);
    tick(); chk("pc4", pc, 32'h4);
    tick(); chk("pc8", pc, 32'h8);
    tick(); chk("pcC", pc, 32'hC);
    tick(); chk("pc10", pc, 32'h10);

    // three wait-states at 0x10
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_pc", pc, 32'h10);
      chk("ws_stall", {31'd0, f_stall}, 32'd1);
      tick();
    end
    im_ready = 1'b1;
    #1;
    chk("ws_rdy_pc", pc, 32'h10);
    chk("ws_rdy_stall", {31'd0, f_stall}, 32'd0);
    tick();
    chk("ws_next_pc", pc, 32'h14);
    chk("ws_err", {31'd0, err}, 32'd0);

    for (int i = 0; i < 11; i++) tick();
    chk("pc40", pc, 32'h40);

    // jump while waiting -> drain; branch during drain wins
    im_ready = 1'b0;
    x_jump   = 1'b1;
    j_tgt    = 32'h200;
    tick();
    x_jump = 1'b0;
    #1;
    chk("drain_pc", pc, 32'h40);
    chk("drain_req", {31'd0, im_req}, 32'd1);
    chk("drain_stall", {31'd0, f_stall}, 32'd1);
    br_taken = 1'b1;
    br_tgt   = 32'h300;
    tick();
    br_taken = 1'b0;
    #1;
    chk("drain2_pc", pc, 32'h40);
    im_ready = 1'b1;
    #1;
    chk("drain_rdy_stall", {31'd0, f_stall}, 32'd1);
    tick();
    chk("drain_done_pc", pc, 32'h300);
    chk("drain_done_stall", {31'd0, f_stall}, 32'd0);

    // branch beats jump in the same cycle
    br_taken = 1'b1;
    br_tgt   = 32'h100;
    x_jump   = 1'b1;
    j_tgt    = 32'h200;
    tick();
    br_taken = 1'b0;
    x_jump   = 1'b0;
    #1;
    chk("prio_pc", pc, 32'h100);

    // misaligned target
    br_taken = 1'b1;
    br_tgt   = 32'h103;
    #1;
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    tick();
    br_taken = 1'b0;
    #1;
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    chk("mis_pc", pc, 32'h100);

    // hazard stall with ready held
    pipe_stall = 1'b1;
    #1;
    chk("hz_stall", {31'd0, f_stall}, 32'd1);
    tick(); chk("hz_pc1", pc, 32'h100);
    tick(); chk("hz_pc2", pc, 32'h100);
    pipe_stall = 1'b0;
    tick(); chk("hz_rel_pc", pc, 32'h104);

    // wrap at top of address space
    x_jump = 1'b1;
    j_tgt  = 32'hFFFF_FFFC;
    tick();
    x_jump = 1'b0;
    #1;
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap_zero", pc, 32'h0);
    tick(); chk("wrap_4", pc, 32'h4);
    tick(); chk("wrap_8", pc, 32'h8);

    // timeout after 15 not-ready cycles
    im_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_err_low", {31'd0, err}, 32'd0);
    end
    chk("to_pc_hold", pc, 32'h8);
    tick();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_req", {31'd0, im_req}, 32'd0);
    chk("to_stall", {31'd0, f_stall}, 32'd1);
    im_ready = 1'b1;
    tick(); tick();
    chk("halt_pc", pc, 32'h8);
    chk("halt_req", {31'd0, im_req}, 32'd0);
    chk("halt_err", {31'd0, err}, 32'd1);

    rst_n = 1'b0;
    #1;
    chk("rerst_err", {31'd0, err}, 32'd0);
    chk("rerst_pc", pc, 32'h0);
    chk("rerst_req", {31'd0, im_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
